// File: rtl/seg_pkg.sv
// Shared types for the UART status display: FSM states and the 5-bit glyph
// code space understood by seg_glyph_dec.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DATA,
        ST_ERR
    } state_t;

    typedef logic [4:0] glyph_t;

    localparam glyph_t HEX0    = 5'd0;
    localparam glyph_t HEX1    = 5'd1;
    localparam glyph_t HEX2    = 5'd2;
    localparam glyph_t HEX3    = 5'd3;
    localparam glyph_t HEX4    = 5'd4;
    localparam glyph_t HEX5    = 5'd5;
    localparam glyph_t HEX6    = 5'd6;
    localparam glyph_t HEX7    = 5'd7;
    localparam glyph_t HEX8    = 5'd8;
    localparam glyph_t HEX9    = 5'd9;
    localparam glyph_t HEXA    = 5'd10;
    localparam glyph_t HEXB    = 5'd11;
    localparam glyph_t HEXC    = 5'd12;
    localparam glyph_t HEXD    = 5'd13;
    localparam glyph_t HEXE    = 5'd14;
    localparam glyph_t HEXF    = 5'd15;
    localparam glyph_t G_L     = 5'd16;
    localparam glyph_t G_O     = 5'd17;
    localparam glyph_t G_R     = 5'd18;
    localparam glyph_t G_BLANK = 5'd19;

    // Hex glyphs occupy codes 0..15, so a nibble maps straight across.
    function automatic glyph_t hex_glyph(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Glyph code plus decimal point to active-low 7-segment pattern (bit7 = dp).
module seg_glyph_dec
    import seg_pkg::*;
(
    input  glyph_t      code,
    input  logic        dp,
    output logic [7:0]  seg
);

    logic [7:0] base;

    always_comb begin
        base = 8'hFF;
        case (code)
            HEX0:    base = 8'hC0;
            HEX1:    base = 8'hF9;
            HEX2:    base = 8'hA4;
            HEX3:    base = 8'hB0;
            HEX4:    base = 8'h99;
            HEX5:    base = 8'h92;
            HEX6:    base = 8'h82;
            HEX7:    base = 8'hF8;
            HEX8:    base = 8'h80;
            HEX9:    base = 8'h90;
            HEXA:    base = 8'h88;
            HEXB:    base = 8'h83;
            HEXC:    base = 8'hC6;
            HEXD:    base = 8'hA1;
            HEXE:    base = 8'h86;
            HEXF:    base = 8'h8E;
            G_L:     base = 8'hC7;
            G_O:     base = 8'hC0;
            G_R:     base = 8'hAF;
            default: base = 8'hFF;
        endcase
        seg = dp ? (base & 8'h7F) : base;
    end

endmodule

// File: rtl/uart_status_seg.sv
// Multiplexed 7-segment status display for the UART/FIR board: idle banner,
// load banner, live last-byte / byte-count view and an error message.
module uart_status_seg
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int SCAN_CYCLES = 50000,
    parameter int HOLD_CYCLES = 100000000,
    parameter int ALT_CYCLES  = 50000000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  uart_en,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_err,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            seg_led
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int ALT_W  = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
    localparam int DIG_W  = $clog2(NUM_DIGITS);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ALT_W-1:0]  ALT_LAST  = ALT_W'(ALT_CYCLES - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic                  sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [DIG_W-1:0]      dig_q, dig_d;
    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [ALT_W-1:0]      alt_cnt_q, alt_cnt_d;
    logic                  alt_q, alt_d;
    logic [7:0]            last_byte_q, last_byte_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
    logic                  dp_tog_q, dp_tog_d;
    logic [7:0]            seg_q, seg_d;

    logic        rise, tick, dp_on;
    logic [31:0] dig_idx;
    glyph_t      glyph;
    logic [7:0]  dec_seg;

    assign rise    = sync2_q & ~edge_q;
    assign tick    = (scan_q == SCAN_LAST);
    assign dig_idx = 32'(dig_q);

    always_comb begin
        sync1_d = uart_en;
        sync2_d = sync1_q;
        edge_d  = sync2_q;

        scan_d = tick ? '0 : scan_q + SCAN_W'(1);
        sel_d  = sel_q;
        dig_d  = dig_q;
        if (tick) begin
            if (&sel_q) begin
                sel_d = {1'b0, {(NUM_DIGITS-1){1'b1}}};
                dig_d = '0;
            end else begin
                sel_d = {sel_q[0], sel_q[NUM_DIGITS-1:1]};
                dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
            end
        end

        last_byte_d = last_byte_q;
        byte_cnt_d  = byte_cnt_q;
        dp_tog_d    = dp_tog_q;
        if (rx_valid) begin
            last_byte_d = rx_data;
            byte_cnt_d  = byte_cnt_q + 8'd1;
            dp_tog_d    = ~dp_tog_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        alt_cnt_d = alt_cnt_q;
        alt_d     = alt_q;
        if (rx_err) begin
            state_d = ST_ERR;
            hold_d  = '0;
        end else if (rise && state_q != ST_ERR) begin
            state_d = ST_LOAD;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_DATA;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_ERR: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (alt_cnt_q == ALT_LAST) begin
                        alt_cnt_d = '0;
                        alt_d     = ~alt_q;
                    end else begin
                        alt_cnt_d = alt_cnt_q + ALT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        // Alternation restarts from "ELEC" every time IDLE is (re)entered.
        if (!(state_q == ST_IDLE && state_d == ST_IDLE)) begin
            alt_cnt_d = '0;
            alt_d     = 1'b0;
        end
    end

    always_comb begin
        glyph = G_BLANK;
        dp_on = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (dig_idx)
                    0: glyph = alt_q ? HEX5 : HEXE;
                    1: glyph = alt_q ? HEX5 : G_L;
                    2: glyph = alt_q ? HEX5 : HEXE;
                    3: glyph = alt_q ? HEX2 : HEXC;
                    default: glyph = G_BLANK;
                endcase
            end
            ST_LOAD: begin
                case (dig_idx)
                    0: glyph = G_L;
                    1: glyph = G_O;
                    2: glyph = HEXA;
                    3: glyph = HEXD;
                    4: glyph = HEXE;
                    5: glyph = HEXD;
                    default: glyph = G_BLANK;
                endcase
            end
            ST_DATA: begin
                case (dig_idx)
                    0: glyph = G_R;
                    2: glyph = hex_glyph(last_byte_q[7:4]);
                    3: begin
                        glyph = hex_glyph(last_byte_q[3:0]);
                        dp_on = dp_tog_q;
                    end
                    4: glyph = (NUM_DIGITS >= 6) ? hex_glyph(byte_cnt_q[7:4]) : G_BLANK;
                    5: glyph = (NUM_DIGITS >= 6) ? hex_glyph(byte_cnt_q[3:0]) : G_BLANK;
                    default: glyph = G_BLANK;
                endcase
            end
            ST_ERR: begin
                case (dig_idx)
                    0: glyph = HEXE;
                    1: glyph = G_R;
                    2: glyph = G_R;
                    default: glyph = G_BLANK;
                endcase
            end
            default: glyph = G_BLANK;
        endcase
    end

    seg_glyph_dec u_dec (
        .code (glyph),
        .dp   (dp_on),
        .seg  (dec_seg)
    );

    assign seg_d = (&sel_q) ? 8'hFF : dec_seg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            scan_q      <= '0;
            sel_q       <= '1;
            dig_q       <= '0;
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            alt_cnt_q   <= '0;
            alt_q       <= 1'b0;
            last_byte_q <= '0;
            byte_cnt_q  <= '0;
            dp_tog_q    <= 1'b0;
            seg_q       <= '1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            scan_q      <= scan_d;
            sel_q       <= sel_d;
            dig_q       <= dig_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            alt_cnt_q   <= alt_cnt_d;
            alt_q       <= alt_d;
            last_byte_q <= last_byte_d;
            byte_cnt_q  <= byte_cnt_d;
            dp_tog_q    <= dp_tog_d;
            seg_q       <= seg_d;
        end
    end

    assign sel     = sel_q;
    assign seg_led = seg_q;

endmodule
